// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundles every non-clock signal of alu_share_arbiter into one interface:
//   two request/response channel pairs and the shared ALU connection.
//
//   Signals
//     reqN_valid   requester N presents an opcode
//     reqN_opcode  {operation[18:16], op1[15:8], op2[7:0]}
//     reqN_ready   arbiter takes requester N's opcode this cycle
//     rspN_valid   result for requester N is available
//     rspN_result  8-bit result for requester N
//     rspN_ready   requester N takes the result
//     alu_*        operation/operands to the ALU, result back from it
//     grant_cnt0/1 accept counters (only with ALU_ARB_STATS_EN defined)
//
//   Modports
//     slave   the arbiter
//     master  requesters + ALU (the environment)
//
//   Optional feature macro: ALU_ARB_STATS_EN
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int CNT_W = 16
);
    logic        req0_valid;
    logic [18:0] req0_opcode;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [7:0]  rsp0_result;
    logic        rsp0_ready;

    logic        req1_valid;
    logic [18:0] req1_opcode;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [7:0]  rsp1_result;
    logic        rsp1_ready;

    logic [2:0]  alu_operation;
    logic [7:0]  alu_op1;
    logic [7:0]  alu_op2;
    logic [7:0]  alu_result;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport slave (
        input  req0_valid, req0_opcode, rsp0_ready,
        input  req1_valid, req1_opcode, rsp1_ready,
        input  alu_result,
        output req0_ready, rsp0_valid, rsp0_result,
        output req1_ready, rsp1_valid, rsp1_result,
        output alu_operation, alu_op1, alu_op2,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_opcode, rsp0_ready,
        output req1_valid, req1_opcode, rsp1_ready,
        output alu_result,
        input  req0_ready, rsp0_valid, rsp0_result,
        input  req1_ready, rsp1_valid, rsp1_result,
        input  alu_operation, alu_op1, alu_op2,
        input  grant_cnt0, grant_cnt1
    );
`else
    modport slave (
        input  req0_valid, req0_opcode, rsp0_ready,
        input  req1_valid, req1_opcode, rsp1_ready,
        input  alu_result,
        output req0_ready, rsp0_valid, rsp0_result,
        output req1_ready, rsp1_valid, rsp1_result,
        output alu_operation, alu_op1, alu_op2
    );

    modport master (
        output req0_valid, req0_opcode, rsp0_ready,
        output req1_valid, req1_opcode, rsp1_ready,
        output alu_result,
        input  req0_ready, rsp0_valid, rsp0_result,
        input  req1_ready, rsp1_valid, rsp1_result,
        input  alu_operation, alu_op1, alu_op2
    );
`endif
endinterface

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational 8-bit ALU between requesters 0 and 1. An opcode
//   is accepted by round-robin arbitration, held in a register that drives the
//   ALU for one cycle, the ALU result is captured and returned on the winner's
//   response channel. Exactly one operation is in flight at a time.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_share_arbiter_if.slave (request/response channels, ALU I/O)
//
//   Parameters
//     LAST_INIT  reset value of the last-granted pointer (1 => requester 0 first)
//     CNT_W      width of the grant counters
//
//   Optional feature macro: ALU_ARB_STATS_EN adds per-requester grant counters
//   (grant_cnt0/1), counting accepted opcodes and wrapping at 2^CNT_W.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter bit LAST_INIT = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [18:0] opcode_q;
    logic [7:0]  result_q;
    logic        winner_q;
    logic        last_grant_q;

    logic        both_valid;
    logic        pick;      // 0 => requester 0 wins, 1 => requester 1 wins
    logic        accept;
    logic        rsp_take;

    always_comb begin
        both_valid = bus.req0_valid & bus.req1_valid;
        // On contention the requester that did not complete last goes next.
        pick       = both_valid ? ~last_grant_q : bus.req1_valid;
        // Qualified with rst_n so no ready can leak out while reset is held.
        accept     = rst_n & (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);
        rsp_take   = winner_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    // NOTE: sequential state is written with non-blocking (<=) so every
    // register samples the pre-edge values; blocking here would create
    // order-dependent simulation and mismatch synthesis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven in this block gets a default first; any
        // path that left one unassigned would infer a latch.
        state_d           = state_q;
        bus.req0_ready    = 1'b0;
        bus.req1_ready    = 1'b0;
        bus.rsp0_valid    = 1'b0;
        bus.rsp1_valid    = 1'b0;
        bus.rsp0_result   = 8'h00;
        bus.rsp1_result   = 8'h00;
        bus.alu_operation = 3'd0;
        bus.alu_op1       = 8'h00;
        bus.alu_op2       = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    bus.req0_ready = ~pick;
                    bus.req1_ready = pick;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                bus.alu_operation = opcode_q[18:16];
                bus.alu_op1       = opcode_q[15:8];
                bus.alu_op2       = opcode_q[7:0];
                state_d           = RESP;
            end
            RESP: begin
                // ALU inputs stay on the held opcode until the result is taken.
                bus.alu_operation = opcode_q[18:16];
                bus.alu_op1       = opcode_q[15:8];
                bus.alu_op2       = opcode_q[7:0];
                bus.rsp0_valid    = ~winner_q;
                bus.rsp1_valid    = winner_q;
                bus.rsp0_result   = winner_q ? 8'h00 : result_q;
                bus.rsp1_result   = winner_q ? result_q : 8'h00;
                if (rsp_take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q     <= '0;
            result_q     <= '0;
            winner_q     <= 1'b0;
            last_grant_q <= LAST_INIT;
        end else begin
            if (accept) begin
                opcode_q <= pick ? bus.req1_opcode : bus.req0_opcode;
                winner_q <= pick;
            end
            if (state_q == EXEC) begin
                result_q <= bus.alu_result;
            end
            // Fairness pointer moves on completion, not on accept.
            if ((state_q == RESP) && rsp_take) begin
                last_grant_q <= winner_q;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_q;
    logic [CNT_W-1:0] grant_cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else if (accept) begin
            if (pick) begin
                grant_cnt1_q <= grant_cnt1_q + 1'b1;
            end else begin
                grant_cnt0_q <= grant_cnt0_q + 1'b1;
            end
        end
    end

    assign bus.grant_cnt0 = grant_cnt0_q;
    assign bus.grant_cnt1 = grant_cnt1_q;
`endif

endmodule
